// File: rtl/snn_pkg.sv
// Shared widths, LFSR polynomial, FSM encoding and per-lane seed derivation for the spike encoder.
package snn_pkg;

  localparam int unsigned BUNDLE_W = 24;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned LFSR_W   = 16;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned STEP_W   = 10;
  localparam int unsigned WORD_W   = BUNDLE_W * PIX_W;

  localparam logic [LFSR_W-1:0] LFSR_POLY   = 16'hB400;
  localparam logic [LFSR_W-1:0] SEED_STRIDE = 16'h1357;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WAIT_Q    = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4,
    STEP_END  = 3'd5,
    FIN       = 3'd6
  } state_t;

  // Lane seed: base + lane*stride modulo 2^16, with the LFSR lock-up value 0 replaced by 1.
  function automatic logic [LFSR_W-1:0] lane_seed(input int unsigned base, input int unsigned lane);
    logic [31:0] s;
    s = 32'(base) + 32'(lane) * 32'(SEED_STRIDE);
    return (s[LFSR_W-1:0] == '0) ? LFSR_W'(1) : s[LFSR_W-1:0];
  endfunction

endpackage

// File: rtl/spike_lfsr.sv
// One 16-bit Galois LFSR lane (x^16+x^14+x^13+x^11+1); reloads its seed on reset, steps when enabled.
module spike_lfsr
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_en,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_next;

  always_comb begin
    w_next = r_state >> 1;
    if (r_state[0]) begin
      w_next = w_next ^ LFSR_POLY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/spike_encoder.sv
// Rate-codes 8-bit pixel intensities into Bernoulli spike bundles, 24 lanes per bundle,
// walking every bundle of the frame once per timestep with a receiver handshake.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int unsigned SEED       = 1000,
  parameter int unsigned NUM_PRE    = 784,
  parameter int unsigned NUM_BUNDLE = 33
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [STEP_W-1:0]   i_num_step,
  input  logic                i_syn_done,
  output logic [ADDR_W-1:0]   addr,
  output logic                ce,
  input  logic [WORD_W-1:0]   q,
  output logic [BUNDLE_W-1:0] o_spike_bundle,
  output logic                o_valid,
  output logic [ADDR_W-1:0]   o_bundle_idx,
  output logic [STEP_W-1:0]   o_step_idx,
  output logic                o_step_end,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [ADDR_W-1:0] LAST_BUNDLE = ADDR_W'(NUM_BUNDLE - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STEP_W-1:0]   r_num_step;
  logic [STEP_W-1:0]   w_num_step_nxt;
  logic [ADDR_W-1:0]   r_bundle;
  logic [ADDR_W-1:0]   w_bundle_nxt;
  logic [STEP_W-1:0]   r_step;
  logic [STEP_W-1:0]   w_step_nxt;
  logic                w_lfsr_en;
  logic [BUNDLE_W-1:0] w_spike;

  logic [ADDR_W-1:0]   r_addr;
  logic                r_ce;
  logic [BUNDLE_W-1:0] r_spike;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_bundle_idx;
  logic                r_step_end;
  logic                r_busy;
  logic                r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and counter updates; i_start and i_syn_done only matter in IDLE / WAIT_DONE.
  always_comb begin
    w_state_nxt    = r_state;
    w_num_step_nxt = r_num_step;
    w_bundle_nxt   = r_bundle;
    w_step_nxt     = r_step;
    w_lfsr_en      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_num_step_nxt = i_num_step;
          w_bundle_nxt   = '0;
          w_step_nxt     = '0;
          w_state_nxt    = (i_num_step == '0) ? FIN : READ;
        end
      end
      READ:   w_state_nxt = WAIT_Q;
      WAIT_Q: w_state_nxt = SEND;
      SEND: begin
        w_lfsr_en   = 1'b1;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_syn_done) begin
          if (r_bundle == LAST_BUNDLE) begin
            w_bundle_nxt = '0;
            w_state_nxt  = STEP_END;
          end else begin
            w_bundle_nxt = ADDR_W'(r_bundle + ADDR_W'(1));
            w_state_nxt  = READ;
          end
        end
      end
      STEP_END: begin
        w_step_nxt  = STEP_W'(r_step + STEP_W'(1));
        w_state_nxt = (STEP_W'(r_step + STEP_W'(1)) == r_num_step) ? FIN : READ;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar k = 0; k < BUNDLE_W; k++) begin : g_lane
    logic [LFSR_W-1:0] w_rnd;
    logic [31:0]       w_gidx;

    spike_lfsr u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_seed  (lane_seed(SEED, k)),
      .i_en    (w_lfsr_en),
      .o_state (w_rnd)
    );

    // Lanes past the last real input (tail of the final bundle) never fire.
    assign w_gidx     = 32'(r_bundle) * 32'(BUNDLE_W) + 32'(k);
    assign w_spike[k] = (w_gidx < 32'(NUM_PRE)) && (q[k*PIX_W +: PIX_W] > w_rnd[PIX_W-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_step   <= '0;
      r_bundle     <= '0;
      r_step       <= '0;
      r_addr       <= '0;
      r_ce         <= 1'b0;
      r_spike      <= '0;
      r_valid      <= 1'b0;
      r_bundle_idx <= '0;
      r_step_end   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_num_step <= w_num_step_nxt;
      r_bundle   <= w_bundle_nxt;
      r_step     <= w_step_nxt;
      r_ce       <= (w_state_nxt == READ);
      if (w_state_nxt == READ) begin
        r_addr <= w_bundle_nxt;
      end
      r_valid <= (r_state == SEND);
      if (r_state == SEND) begin
        r_spike      <= w_spike;
        r_bundle_idx <= r_bundle;
      end
      r_step_end <= (w_state_nxt == STEP_END);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == FIN);
    end
  end

  assign addr           = r_addr;
  assign ce             = r_ce;
  assign o_spike_bundle = r_spike;
  assign o_valid        = r_valid;
  assign o_bundle_idx   = r_bundle_idx;
  assign o_step_idx     = r_step;
  assign o_step_end     = r_step_end;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: SPBRAM model, receiver handshake and an independent lane LFSR model.
module tb_spike_encoder;

  localparam int NB = 33;
  localparam int NP = 784;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [9:0]   i_num_step;
  logic         i_syn_done;
  logic [5:0]   addr;
  logic         ce;
  logic [191:0] q;
  logic [23:0]  o_spike_bundle;
  logic         o_valid;
  logic [5:0]   o_bundle_idx;
  logic [9:0]   o_step_idx;
  logic         o_step_end;
  logic         o_busy;
  logic         o_done;

  spike_encoder #(.SEED(1000), .NUM_PRE(784), .NUM_BUNDLE(33)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_num_step     (i_num_step),
    .i_syn_done     (i_syn_done),
    .addr           (addr),
    .ce             (ce),
    .q              (q),
    .o_spike_bundle (o_spike_bundle),
    .o_valid        (o_valid),
    .o_bundle_idx   (o_bundle_idx),
    .o_step_idx     (o_step_idx),
    .o_step_end     (o_step_end),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  logic [191:0] mem [64];
  always @(posedge clk) if (ce) q <= mem[addr];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mlfsr [24];
  logic [23:0] rec [66];
  int lane_cnt [33][24];
  int nvalid, nstep_end, ndone, first_valid_cyc, done_cyc, stall_bad, rec_bad, any_spike;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n[15]  = s[0];
    n[14]  = s[15];
    n[13]  = s[14] ^ s[0];
    n[12]  = s[13] ^ s[0];
    n[11]  = s[12];
    n[10]  = s[11] ^ s[0];
    n[9:0] = s[10:1];
    return n;
  endfunction

  task automatic model_reset();
    logic [31:0] s;
    for (int k = 0; k < 24; k++) begin
      s = 32'(1000 + k * 4951);
      mlfsr[k] = (s[15:0] == 16'd0) ? 16'd1 : s[15:0];
    end
  endtask

  function automatic logic [23:0] model_bundle(input int b);
    logic [23:0]  v;
    logic [7:0]   pix;
    logic [191:0] w;
    logic [15:0]  r;
    w = mem[b];
    v = '0;
    for (int k = 0; k < 24; k++) begin
      pix = w[k*8 +: 8];
      r   = mlfsr[k];
      if ((b * 24 + k) < NP && pix > r[7:0]) v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic fill_mem(input int mode);
    logic [7:0] pix;
    for (int b = 0; b < 64; b++) begin
      mem[b] = '0;
      for (int k = 0; k < 24; k++) begin
        if (mode == 0)      pix = 8'd0;
        else if (mode == 2) pix = 8'd255;
        else                pix = (k % 7 == 0) ? 8'd0 : 8'((b * 37 + k * 53 + 7) % 256);
        mem[b][k*8 +: 8] = pix;
      end
    end
  endtask

  task automatic run_frame(input int ns, input int stall_at, input int restart_cyc,
                           input bit abort, input int rec_mode, input bit cnt_en);
    int cyc, pend, exp_b, exp_s, idx;
    bit fin;
    logic [23:0] exp_v;
    nvalid = 0; nstep_end = 0; ndone = 0; first_valid_cyc = -1; done_cyc = -1;
    stall_bad = 0; rec_bad = 0; any_spike = 0;
    exp_b = 0; exp_s = 0; pend = -1; fin = 1'b0; cyc = 0;
    i_num_step = 10'(ns);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    while (!fin && cyc < 30000) begin
      i_syn_done = 1'b0;
      i_start    = (cyc == restart_cyc);
      i_num_step = (cyc == restart_cyc) ? 10'd5 : 10'(ns);
      if (cyc == 1 && ns > 0) check("busy_in_frame", 32'(o_busy), 32'd1);
      if (pend > 0 && (ce || o_valid)) stall_bad++;
      if (o_step_end) nstep_end++;
      if (o_done) begin
        ndone++;
        done_cyc = cyc;
        fin = 1'b1;
      end
      if (o_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        exp_v = model_bundle(exp_b);
        check("bundle_idx", 32'(o_bundle_idx), 32'(exp_b));
        check("step_idx", 32'(o_step_idx), 32'(exp_s));
        check("spikes", 32'(o_spike_bundle), 32'(exp_v));
        if (o_spike_bundle != 24'd0) any_spike++;
        idx = exp_s * NB + exp_b;
        if (rec_mode == 1 && idx < 2 * NB) rec[idx] = o_spike_bundle;
        if (rec_mode == 2 && idx < 2 * NB && rec[idx] !== o_spike_bundle) rec_bad++;
        if (cnt_en) for (int k = 0; k < 24; k++) if (o_spike_bundle[k]) lane_cnt[exp_b][k]++;
        for (int k = 0; k < 24; k++) mlfsr[k] = lfsr_step(mlfsr[k]);
        if (abort && exp_s == 1 && exp_b == 10) begin
          rst_n = 1'b0;
          #1;
          check("rst_valid", 32'(o_valid), 32'd0);
          check("rst_spikes", 32'(o_spike_bundle), 32'd0);
          check("rst_bundle_idx", 32'(o_bundle_idx), 32'd0);
          check("rst_step_idx", 32'(o_step_idx), 32'd0);
          check("rst_busy", 32'(o_busy), 32'd0);
          check("rst_ce_addr", {25'd0, ce, addr}, 32'd0);
          @(negedge clk);
          rst_n = 1'b1;
          model_reset();
          fin = 1'b1;
        end
        exp_b++;
        if (exp_b == NB) begin
          exp_b = 0;
          exp_s++;
        end
        pend = (nvalid == stall_at) ? 50 : 0;
        nvalid++;
      end
      if (!fin) begin
        if (pend == 0) begin
          i_syn_done = 1'b1;
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check("frame_terminates", 32'(fin), 32'd1);
    i_start = 1'b0;
    i_syn_done = 1'b0;
  endtask

  initial begin
    int min_cnt, masked;
    i_start = 1'b0; i_num_step = '0; i_syn_done = 1'b0;
    rst_n = 1'b1;
    fill_mem(1);
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_spikes", 32'(o_spike_bundle), 32'd0);
    check("reset_bundle_idx", 32'(o_bundle_idx), 32'd0);
    check("reset_step_idx", 32'(o_step_idx), 32'd0);
    check("reset_step_end", 32'(o_step_end), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_ce", 32'(ce), 32'd0);
    check("reset_addr", 32'(addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // Stray handshake while idle must not start anything.
    i_syn_done = 1'b1;
    @(negedge clk);
    i_syn_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_syn_busy", 32'(o_busy), 32'd0);
    check("stray_syn_ce", 32'(ce), 32'd0);
    check("stray_syn_valid", 32'(o_valid), 32'd0);

    // Frame A: mixed pixels, two steps, recorded for the reproducibility check.
    run_frame(2, -1, -1, 1'b0, 1, 1'b0);
    check("A_valids", 32'(nvalid), 32'd66);
    check("A_step_ends", 32'(nstep_end), 32'd2);
    check("A_dones", 32'(ndone), 32'd1);
    check("A_first_valid_latency", 32'(first_valid_cyc), 32'd3);
    check("A_has_spikes", 32'(any_spike > 0), 32'd1);
    @(negedge clk);
    check("A_idle_after", 32'(o_busy), 32'd0);

    // Frame B: asynchronous reset at step 1 bundle 10.
    run_frame(2, -1, -1, 1'b1, 0, 1'b0);
    check("B_valids_before_abort", 32'(nvalid), 32'd44);
    @(negedge clk);

    // Frame C: same pixels after reset must match frame A bit-exactly.
    run_frame(2, -1, -1, 1'b0, 2, 1'b0);
    check("C_valids", 32'(nvalid), 32'd66);
    check("C_repro", 32'(rec_bad), 32'd0);
    @(negedge clk);

    // All-zero pixels with a long receiver stall and a stray mid-frame start.
    fill_mem(0);
    run_frame(2, 5, 150, 1'b0, 0, 1'b0);
    check("Z_valids", 32'(nvalid), 32'd66);
    check("Z_step_ends", 32'(nstep_end), 32'd2);
    check("Z_dones", 32'(ndone), 32'd1);
    check("Z_no_spikes", 32'(any_spike), 32'd0);
    check("Z_stall_quiet", 32'(stall_bad), 32'd0);
    @(negedge clk);

    // Zero timesteps: straight to done.
    run_frame(0, -1, -1, 1'b0, 0, 1'b0);
    check("N0_valids", 32'(nvalid), 32'd0);
    check("N0_dones", 32'(ndone), 32'd1);
    check("N0_done_within_3", 32'(done_cyc >= 0 && done_cyc <= 3), 32'd1);
    @(negedge clk);
    check("N0_idle_after", 32'(o_busy), 32'd0);

    // All-255 pixels over 100 steps.
    fill_mem(2);
    for (int b = 0; b < 33; b++) for (int k = 0; k < 24; k++) lane_cnt[b][k] = 0;
    run_frame(100, -1, -1, 1'b0, 0, 1'b1);
    check("F_valids", 32'(nvalid), 32'd3300);
    check("F_step_ends", 32'(nstep_end), 32'd100);
    check("F_dones", 32'(ndone), 32'd1);
    min_cnt = 1000;
    masked  = 0;
    for (int b = 0; b < 33; b++) begin
      for (int k = 0; k < 24; k++) begin
        if (b * 24 + k < NP) begin
          if (lane_cnt[b][k] < min_cnt) min_cnt = lane_cnt[b][k];
        end else begin
          masked += lane_cnt[b][k];
        end
      end
    end
    check("F_min_lane_spikes_ge_95", 32'(min_cnt >= 95), 32'd1);
    check("F_masked_lanes_silent", 32'(masked), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 The block SHALL take parameter SEED, default 1000, as the base seed for the random lanes.
REQ-002 The block SHALL take parameter NUM_PRE, default 784, as the number of valid pre-synaptic inputs.
REQ-003 The block SHALL take parameter NUM_BUNDLE, default 33, as the number of bundles per timestep (ceil(NUM_PRE/24)).
REQ-004 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse that starts a frame.
- i_num_step  in  10  timesteps per frame, sampled with i_start.
- i_syn_done  in  1  receiver finished the current bundle.
- addr  out  6  pixel SPBRAM address (bundle index).
- ce  out  1  pixel SPBRAM read enable.
- q  in  192  pixel word, 24 lanes x 8-bit unsigned intensity, lane k at bits [8k+:8].
- o_spike_bundle  out  24  spikes for the current bundle.
- o_valid  out  1  one-cycle bundle strobe.
- o_bundle_idx  out  6  index of the bundle on o_spike_bundle.
- o_step_idx  out  10  current timestep.
- o_step_end  out  1  one-cycle pulse after the last bundle of a step is done.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse at frame end.

Function
REQ-005 The FSM SHALL have states IDLE, READ, WAIT_Q, SEND, WAIT_DONE, STEP_END, FIN.
REQ-006 In IDLE, an i_start pulse SHALL latch i_num_step, clear the bundle and step counters, and go to READ; with i_num_step=0 it SHALL go to FIN instead.
REQ-007 READ SHALL drive ce=1 and addr=bundle index for exactly one cycle; WAIT_Q SHALL wait one cycle for the 1-cycle SPBRAM read latency.
REQ-008 SEND SHALL assert o_valid for exactly one cycle with o_spike_bundle, o_bundle_idx and o_step_idx stable; the first o_valid SHALL occur 3 cycles after i_start is sampled.
REQ-009 Lane k SHALL spike iff pixel_k > rnd_k (unsigned 8-bit), where rnd_k is the low 8 bits of LFSR lane k; pixel 0 never spikes.
REQ-010 Lanes whose global index 24*bundle+k >= NUM_PRE SHALL be forced to 0; with the defaults, bundle 32 lanes 16..23 are always 0.
REQ-011 All 24 LFSR lanes SHALL advance exactly once per SEND cycle and never otherwise.
REQ-012 WAIT_DONE SHALL hold until i_syn_done=1, then go to READ for the next bundle, or to STEP_END after bundle NUM_BUNDLE-1; i_syn_done in any other state SHALL be ignored.
REQ-013 STEP_END SHALL pulse o_step_end for one cycle, increment the step counter, and go to READ if steps remain, else to FIN.
REQ-014 FIN SHALL pulse o_done for one cycle and return to IDLE.
REQ-015 o_busy SHALL be 1 in every state except IDLE; i_start while o_busy=1 SHALL be ignored.
REQ-016 All outputs SHALL be registered; o_spike_bundle SHALL hold its last value outside SEND, and only o_valid qualifies it.

Reset
REQ-017 On rst_n=0 the FSM SHALL go to IDLE immediately, including mid-frame.
REQ-018 On rst_n=0 all counters and outputs SHALL go to 0.
REQ-019 On rst_n=0 each LFSR lane k SHALL reload seed (SEED + k*0x1357) mod 2^16, and a zero seed SHALL be replaced by 0x0001.

Structure
REQ-020 Shared package snn_pkg SHALL hold BUNDLE_W=24, PIX_W=8, LFSR_W=16, LFSR_POLY=16'hB400 and the FSM state encoding.
REQ-021 Sub-module spike_lfsr SHALL hold one 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with seed input and advance enable; it SHALL be instantiated 24 times.

Verification
REQ-022 All-zero pixels, i_num_step=2 -> 66 o_valid strobes, every bundle 0, 2 o_step_end pulses, 1 o_done.
REQ-023 All-255 pixels, i_num_step=100 -> each valid lane spikes at least 95 times; bundle 32 lanes 16..23 are never 1.
REQ-024 i_start with i_num_step=0 -> no o_valid, and o_done pulses within 3 cycles.
REQ-025 i_syn_done held low for 50 cycles after o_valid -> no further ce or o_valid until it rises; a stray i_syn_done pulse in IDLE -> no effect.
REQ-026 rst_n pulsed low at step 1, bundle 10 -> outputs go to 0 asynchronously; the next frame with the same pixels reproduces the first frame's bundles bit-exactly.
REQ-027 i_start pulsed again mid-frame -> ignored; o_step_idx and o_bundle_idx continue uninterrupted.
